// File: rtl/decoder_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decoder_rr_arbiter_pkg                                 |
// | Description : Shared sizes, FSM state type and the round-robin       |
// |               winner search used by decoder_rr_arbiter.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package decoder_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  // Saturation value of the hold counter
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Scan upward from last_idx+1 with wrap; last_idx itself is checked last.
  // Returns {found, idx}; idx is 0 when nothing is requesting.
  function automatic logic [IDX_W:0] next_rr_winner(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   last_idx
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // The 3-bit add wraps modulo NUM_REQ on its own
      cand = last_idx + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_3bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decoder_3bit                                           |
// | Description : 3-to-8 one-hot decoder.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module decoder_3bit (
  input  logic [2:0] sel_i,
  output logic [7:0] dec_o
);

  // Exactly one output bit set for every select value
  always_comb begin
    dec_o = 8'h01 << sel_i;
  end

endmodule
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decoder_rr_arbiter                                     |
// | Description : 8-requester round-robin arbiter. A grant is held while |
// |               the owner keeps requesting and is always followed by   |
// |               one idle cycle. Outputs a registered index and a       |
// |               one-hot grant decoded from it.                         |
// | Options     : DECODER_RR_ARBITER_TIMEOUT_EN - revoke a grant after   |
// |               HOLD_MAX cycles of continuous ownership.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic [CNT_W-1:0]   busy_cycles
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range_check
    $error("decoder_rr_arbiter: HOLD_MAX must be within 2..255");
  end

  state_e             state_q,     state_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
  logic [IDX_W-1:0]   last_idx_q,  last_idx_d;
  logic [CNT_W-1:0]   busy_q,      busy_d;

  logic [IDX_W:0]     winner;
  logic               owner_req;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] dec_onehot;

  assign winner    = next_rr_winner(req, last_idx_q);
  assign owner_req = req[gnt_idx_q];

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
  // Ownership has lasted HOLD_MAX cycles: treat the next edge as a release
  assign timeout_hit = (busy_q == CNT_W'(HOLD_MAX));
`else
  assign timeout_hit = 1'b0;
`endif

  // State and output registers; reset makes requester 0 first in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_idx_q  <= last_idx_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: arbitrate only in IDLE, hold or release in GRANT
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    last_idx_d  = last_idx_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (winner[IDX_W]) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = winner[IDX_W-1:0];
          last_idx_d  = winner[IDX_W-1:0];
          busy_d      = CNT_W'(1);
        end
      end
      GRANT: begin
        if (owner_req && !timeout_hit) begin
          busy_d = (busy_q == CNT_MAX) ? busy_q : busy_q + CNT_W'(1);
        end else begin
          // last_idx is kept so the departing owner scans last next time
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
          busy_d      = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
        busy_d      = '0;
      end
    endcase
  end

  decoder_3bit u_decoder (
    .sel_i (gnt_idx_q),
    .dec_o (dec_onehot)
  );

  // Grant is purely a function of registers, so req never reaches gnt
  assign gnt         = dec_onehot & {NUM_REQ{gnt_valid_q}};
  assign gnt_valid   = gnt_valid_q;
  assign gnt_idx     = gnt_idx_q;
  assign busy_cycles = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_decoder_rr_arbiter                                  |
// | Description : Self-checking bench for decoder_rr_arbiter: directed   |
// |               scenarios with literal expectations plus randomized    |
// |               traffic compared every cycle against a reference model.|
// | Options     : DECODER_RR_ARBITER_TIMEOUT_EN (runs with HOLD_MAX=4).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_decoder_rr_arbiter;

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic [7:0] busy_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx),
    .gnt         (gnt),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how long, and who went last
  bit         m_valid;
  logic [2:0] m_idx;
  int         m_busy;
  int         m_last;

  always @(posedge clk or posedge rst) begin
    bit found;
    bit revoke;
    if (rst) begin
      m_valid = 0;
      m_idx   = 3'd0;
      m_busy  = 0;
      m_last  = 7;
    end else if (!m_valid) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(m_last + k) % 8]) begin
          found   = 1;
          m_last  = (m_last + k) % 8;
        end
      end
      if (found) begin
        m_valid = 1;
        m_idx   = m_last[2:0];
        m_busy  = 1;
      end
    end else begin
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
      revoke = (m_busy == HOLD);
`else
      revoke = 0;
`endif
      if (req[m_idx] && !revoke) begin
        m_busy = (m_busy < 255) ? m_busy + 1 : 255;
      end else begin
        m_valid = 0;
        m_idx   = 3'd0;
        m_busy  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {valid,idx,gnt,busy}=%h required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {gnt_valid, gnt_idx, gnt, busy_cycles};
  endfunction

  // Literal expectation: valid, idx, one-hot gnt, busy
  task automatic expect_lit(input string name, input logic v, input logic [2:0] idx,
                            input logic [7:0] g, input logic [7:0] busy);
    check(name, outs(), {v, idx, g, busy});
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [7:0] eg;
    logic [7:0] eb;
    eg = m_valid ? (8'h01 << m_idx) : 8'h00;
    eb = 8'(m_busy);
    check("model", outs(), {m_valid, m_idx, eg, eb});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
    expect_lit("reset_state", 1'b0, 3'd0, 8'h00, 8'd0);
  endtask

  initial begin
    // Idle after reset with no requests
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      expect_lit("idle_no_req", 1'b0, 3'd0, 8'h00, 8'd0);
    end

    // Single-cycle request from requester 0
    req = 8'h01;
    step();
    expect_lit("first_grant_0", 1'b1, 3'd0, 8'h01, 8'd1);
    req = 8'h00;
    step();
    expect_lit("release_dead", 1'b0, 3'd0, 8'h00, 8'd0);

    // All requesting; each owner drops for one cycle -> 0..7,0
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      req = 8'hFF;
      step();
      expect_lit("rr_order", 1'b1, 3'(k % 8), 8'h01 << (k % 8), 8'd1);
      req = 8'hFF & ~(8'h01 << (k % 8));
      step();
      expect_lit("rr_dead", 1'b0, 3'd0, 8'h00, 8'd0);
    end

    // Wrap: after granting 6, bits 0 and 6 -> 0 wins
    req = 8'h40;
    step();
    expect_lit("wrap_grant_6", 1'b1, 3'd6, 8'h40, 8'd1);
    req = 8'h01;
    step();
    expect_lit("wrap_dead", 1'b0, 3'd0, 8'h00, 8'd0);
    req = 8'h41;
    step();
    expect_lit("wrap_grant_0", 1'b1, 3'd0, 8'h01, 8'd1);
    req = 8'h00;
    step();

`ifndef DECODER_RR_ARBITER_TIMEOUT_EN
    // Hold: 2 held for 20 cycles, then 5
    req = 8'h24;
    step();
    for (int i = 1; i <= 20; i++) begin
      expect_lit("hold_count", 1'b1, 3'd2, 8'h04, 8'(i));
      if (i < 20) step();
    end
    req = 8'h20;
    step();
    expect_lit("hold_release", 1'b0, 3'd0, 8'h00, 8'd0);
    step();
    expect_lit("hold_next_5", 1'b1, 3'd5, 8'h20, 8'd1);
    req = 8'h00;
    step();
`endif

    // Asynchronous reset in the middle of a grant to 4
    req = 8'h10;
    step();
    expect_lit("pre_reset_grant_4", 1'b1, 3'd4, 8'h10, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    expect_lit("async_reset_drop", 1'b0, 3'd0, 8'h00, 8'd0);
    req = 8'h11;
    step();
    rst = 1'b0;
    step();
    expect_lit("post_reset_grant_0", 1'b1, 3'd0, 8'h01, 8'd1);
    req = 8'h00;
    step();

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    // Timeout: two requesters share via revocation after HOLD cycles
    do_reset();
    req = 8'h03;
    step();
    for (int i = 1; i <= 4; i++) begin
      expect_lit("to_grant_0", 1'b1, 3'd0, 8'h01, 8'(i));
      step();
    end
    expect_lit("to_dead_0", 1'b0, 3'd0, 8'h00, 8'd0);
    step();
    for (int i = 1; i <= 4; i++) begin
      expect_lit("to_grant_1", 1'b1, 3'd1, 8'h02, 8'(i));
      step();
    end
    expect_lit("to_dead_1", 1'b0, 3'd0, 8'h00, 8'd0);
    step();
    expect_lit("to_regrant_0", 1'b1, 3'd0, 8'h01, 8'd1);
`else
    // Saturation of the hold counter
    do_reset();
    req = 8'h80;
    for (int i = 0; i < 260; i++) step();
    expect_lit("busy_saturate", 1'b1, 3'd7, 8'h80, 8'd255);
`endif

    // Randomized traffic checked by the model every cycle
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r >= 6) req = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      step();
    end

    req = 8'h00;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
